// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit: prefetch entry layout, reset PC, NOP.
// Combinational only; no flow control.
package ifu_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          INSTR_BYTES      = 4;
   localparam logic [31:0] NOP              = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault;
   } fifo_entry_t;

   localparam int ENTRY_W = $bits(fifo_entry_t);

   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + 32'(INSTR_BYTES);
   endfunction

endpackage

// File: rtl/ifu_if.sv
// Fetch-unit bus bundle: imem req/gnt/rvalid, redirect pulse and decoder valid/ready.
// master = fetch unit side, slave = memory/decoder/control side.
interface ifu_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_fault;

   modport master (
      output imem_req, imem_addr, if_valid, if_instr, if_pc, if_fault,
      input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
   );

   modport slave (
      input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_fault,
      output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
   );

endinterface

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; head is registered storage (push visible next cycle, no bypass).
// Flush dominates push/pop; a push into a full FIFO is taken only together with a pop.
module ifu_fifo #(
   parameter int             W         = 32,
   parameter int             DEPTH     = 2,
   parameter logic [W-1:0]   RESET_VAL = '0,
   localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int            CW        = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic [W-1:0]  push_dat_i,
   input  logic          pop_i,
   output logic [W-1:0]  head_dat_o,
   output logic [CW-1:0] count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop, full;

   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   assign head_dat_o = mem_q[rd_ptr_q];
   assign count_o    = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: credit-limited imem requests, in-order prefetch FIFO to decoder (rvalid N -> if_valid N+1).
// Redirects flush and drain in-flight words; IFU_MISALIGN_CHECK_EN turns misaligned targets into one fault entry.
module instruction_fetch_unit
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH = 2
) (
   input logic   clk,
   input logic   rst_n,
   ifu_if.master bus
);

   localparam int                 CW       = $clog2(FIFO_DEPTH + 1);
   localparam logic [ENTRY_W-1:0] PF_RESET = {32'h0, RESET_PC, 1'b0};

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] disc_q, disc_d;
   logic          run_q;
   logic          redirect, granted, tag_pop, fetch_ok, fault_push;
   logic [31:0]   redir_pc, tag_pc;
   logic [CW-1:0] pf_cnt, tag_cnt, outstanding;
   fifo_entry_t   pf_push_dat, pf_head;

   assign redirect = bus.redirect_valid;
   // Responses still owed = tagged (kept) requests plus those marked for discard.
   assign outstanding = tag_cnt + disc_q;

   assign bus.imem_req  = run_q && fetch_ok && !redirect &&
                          (({1'b0, pf_cnt} + {1'b0, outstanding}) < (CW + 1)'(FIFO_DEPTH));
   assign bus.imem_addr = pc_q;
   assign granted       = bus.imem_req && bus.imem_gnt;
   assign tag_pop       = bus.imem_rvalid && (disc_q == '0);

   always_comb begin
      disc_d = disc_q;
      if (redirect)
         disc_d = outstanding - CW'(bus.imem_rvalid);
      else if (bus.imem_rvalid && (disc_q != '0))
         disc_d = disc_q - CW'(1);
   end

   always_comb begin
      pc_d = pc_q;
      if (redirect)     pc_d = redir_pc;
      else if (granted) pc_d = next_pc(pc_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= RESET_PC;
         disc_q <= '0;
         run_q  <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         disc_q <= disc_d;
         run_q  <= 1'b1;
      end
   end

`ifdef IFU_MISALIGN_CHECK_EN
   logic mis_pend_q, mis_pend_d, halt_q, halt_d;

   // pc_q holds the misaligned target while halted, so it doubles as the fault PC.
   always_comb begin
      mis_pend_d = mis_pend_q;
      halt_d     = halt_q;
      fault_push = 1'b0;
      if (redirect) begin
         mis_pend_d = (bus.redirect_pc[1:0] != 2'b00);
         halt_d     = 1'b0;
      end else if (mis_pend_q && (outstanding == '0)) begin
         fault_push = 1'b1;
         mis_pend_d = 1'b0;
         halt_d     = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mis_pend_q <= 1'b0;
         halt_q     <= 1'b0;
      end else begin
         mis_pend_q <= mis_pend_d;
         halt_q     <= halt_d;
      end
   end

   assign fetch_ok = !mis_pend_q && !halt_q;
   assign redir_pc = bus.redirect_pc;
`else
   assign fetch_ok   = 1'b1;
   assign fault_push = 1'b0;
   assign redir_pc   = bus.redirect_pc & 32'hFFFF_FFFC;
`endif

   always_comb begin
      pf_push_dat = '{instr: bus.imem_rdata, pc: tag_pc, fault: 1'b0};
      if (fault_push) pf_push_dat = '{instr: 32'h0, pc: pc_q, fault: 1'b1};
   end

   ifu_fifo #(.W(32), .DEPTH(FIFO_DEPTH), .RESET_VAL(RESET_PC)) u_tag_q (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (redirect),
      .push_i     (granted),
      .push_dat_i (pc_q),
      .pop_i      (tag_pop),
      .head_dat_o (tag_pc),
      .count_o    (tag_cnt)
   );

   ifu_fifo #(.W(ENTRY_W), .DEPTH(FIFO_DEPTH), .RESET_VAL(PF_RESET)) u_prefetch_q (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (redirect),
      .push_i     (tag_pop || fault_push),
      .push_dat_i (pf_push_dat),
      .pop_i      (bus.if_valid && bus.if_ready),
      .head_dat_o (pf_head),
      .count_o    (pf_cnt)
   );

   // Without the misalign check no fault entry is ever pushed, so the fault bit stays 0.
   assign bus.if_valid = (pf_cnt != '0);
   assign bus.if_instr = pf_head.instr;
   assign bus.if_pc    = pf_head.pc;
   assign bus.if_fault = pf_head.fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, stall/misalign/reset sequences, random traffic vs queue model.
module tb_instruction_fetch_unit;
   import ifu_pkg::*;

   localparam int DEPTH = 2;
   localparam bit T = 1'b1;
   localparam bit F = 1'b0;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   ifu_if bus();

   instruction_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] pc;
      bit          stale;
      int          gcyc;
   } infl_t;

   typedef struct {
      bit g, rv, rdr;
      logic [31:0] rpc;
      bit rdy, e_req;
      logic [31:0] e_addr;
      bit e_vld;
      logic [31:0] e_pc;
   } vec_t;

   infl_t       infl[$];
   fifo_entry_t mq[$];
   logic [31:0] m_pc;
   int          mode;
   int          cyc, checks, errors;

   logic        o_req, o_vld, o_fault;
   logic [31:0] o_addr, o_instr, o_pc;

   function automatic logic [31:0] memw(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ NOP;
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic vec_t mk(bit g, bit rv, bit rdr, logic [31:0] rpc, bit rdy,
                               bit er, logic [31:0] ea, bit ev, logic [31:0] ep);
      vec_t v;
      v = '{g: g, rv: rv, rdr: rdr, rpc: rpc, rdy: rdy, e_req: er, e_addr: ea, e_vld: ev, e_pc: ep};
      return v;
   endfunction

   // One clock: drive at negedge, compare against the queue model, then advance the model.
   task automatic step(input bit g, input bit rv_in, input bit rdr, input logic [31:0] rpc, input bit rdy);
      bit p_req, p_vld, rv;
      infl_t e;
      @(negedge clk);
      rv = 1'b0;
      if (rv_in && infl.size() > 0)
         if (infl[0].gcyc < cyc) rv = 1'b1;
      bus.imem_gnt       = g;
      bus.imem_rvalid    = rv;
      bus.imem_rdata     = rv ? memw(infl[0].pc) : $urandom;
      bus.redirect_valid = rdr;
      bus.redirect_pc    = rpc;
      bus.if_ready       = rdy;
      #1;
      o_req = bus.imem_req;   o_addr = bus.imem_addr; o_vld = bus.if_valid;
      o_instr = bus.if_instr; o_pc = bus.if_pc;       o_fault = bus.if_fault;
      p_req = !rdr && (mode == 0) && (mq.size() + infl.size() < DEPTH);
      p_vld = (mq.size() > 0);
      chk("imem_req", 32'(o_req), 32'(p_req));
      if (p_req) chk("imem_addr", o_addr, m_pc);
      chk("if_valid", 32'(o_vld), 32'(p_vld));
      if (p_vld) begin
         chk("if_pc", o_pc, mq[0].pc);
         chk("if_instr", o_instr, mq[0].instr);
         chk("if_fault", 32'(o_fault), 32'(mq[0].fault));
      end
      if (p_vld && rdy && !rdr) mq.delete(0);
      if (mode == 1 && infl.size() == 0 && !rdr) begin
         mq.push_back({32'h0, m_pc, 1'b1});
         mode = 2;
      end
      if (rv) begin
         e = infl[0];
         infl.delete(0);
         if (!e.stale && !rdr) mq.push_back({memw(e.pc), e.pc, 1'b0});
      end
      if (p_req && g) begin
         infl.push_back('{pc: m_pc, stale: 1'b0, gcyc: cyc});
         m_pc += 32'd4;
      end
      if (rdr) begin
         mq.delete();
         foreach (infl[i]) infl[i].stale = 1'b1;
`ifdef IFU_MISALIGN_CHECK_EN
         m_pc = rpc;
         mode = (rpc[1:0] != 2'b00) ? 1 : 0;
`else
         m_pc = {rpc[31:2], 2'b00};
`endif
      end
      cyc++;
   endtask

   // Reset asserted mid-cycle: outputs must take reset values without waiting for a clock.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
      bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.if_ready = 1'b0;
      #1;
      chk("rst_imem_req", 32'(bus.imem_req), 32'h0);
      chk("rst_if_valid", 32'(bus.if_valid), 32'h0);
      chk("rst_if_instr", bus.if_instr, 32'h0);
      chk("rst_if_pc", bus.if_pc, 32'h0);
      chk("rst_if_fault", 32'(bus.if_fault), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      infl.delete(); mq.delete();
      m_pc = 32'h0; mode = 0; cyc = 0;
   endtask

   vec_t tbl[22];
   int   n;
   logic [31:0] rpc;

   initial begin
      checks = 0; errors = 0; cyc = 0; mode = 0; m_pc = 32'h0;
      tbl[0]  = mk(T, F, F, 32'h0,   T, T, 32'h0,   F, 32'h0);
      tbl[1]  = mk(F, T, F, 32'h0,   T, T, 32'h4,   F, 32'h0);
      tbl[2]  = mk(F, F, F, 32'h0,   F, T, 32'h4,   T, 32'h0);
      tbl[3]  = mk(F, F, F, 32'h0,   F, T, 32'h4,   T, 32'h0);
      tbl[4]  = mk(T, F, F, 32'h0,   F, T, 32'h4,   T, 32'h0);
      tbl[5]  = mk(T, F, F, 32'h0,   F, F, 32'h0,   T, 32'h0);
      tbl[6]  = mk(T, T, F, 32'h0,   F, F, 32'h0,   T, 32'h0);
      tbl[7]  = mk(T, F, F, 32'h0,   F, F, 32'h0,   T, 32'h0);
      tbl[8]  = mk(T, F, F, 32'h0,   T, F, 32'h0,   T, 32'h0);
      tbl[9]  = mk(T, F, F, 32'h0,   T, T, 32'h8,   T, 32'h4);
      tbl[10] = mk(T, F, F, 32'h0,   T, T, 32'hC,   F, 32'h0);
      tbl[11] = mk(T, F, T, 32'h100, T, F, 32'h0,   F, 32'h0);
      tbl[12] = mk(T, T, F, 32'h0,   T, F, 32'h0,   F, 32'h0);
      tbl[13] = mk(T, T, F, 32'h0,   T, T, 32'h100, F, 32'h0);
      tbl[14] = mk(T, T, F, 32'h0,   T, T, 32'h104, F, 32'h0);
      tbl[15] = mk(F, F, F, 32'h0,   T, F, 32'h0,   T, 32'h100);
      tbl[16] = mk(F, T, F, 32'h0,   F, T, 32'h108, F, 32'h0);
      tbl[17] = mk(T, F, T, 32'h40,  T, F, 32'h0,   T, 32'h104);
      tbl[18] = mk(T, F, F, 32'h0,   T, T, 32'h40,  F, 32'h0);
      tbl[19] = mk(T, T, F, 32'h0,   T, T, 32'h44,  F, 32'h0);
      tbl[20] = mk(F, T, T, 32'h80,  T, F, 32'h0,   T, 32'h40);
      tbl[21] = mk(F, F, F, 32'h0,   T, T, 32'h80,  F, 32'h0);

      do_reset();
      for (int i = 0; i < 22; i++) begin
         step(tbl[i].g, tbl[i].rv, tbl[i].rdr, tbl[i].rpc, tbl[i].rdy);
         chk($sformatf("vec%0d_req", i), 32'(o_req), 32'(tbl[i].e_req));
         if (tbl[i].e_req) chk($sformatf("vec%0d_addr", i), o_addr, tbl[i].e_addr);
         chk($sformatf("vec%0d_vld", i), 32'(o_vld), 32'(tbl[i].e_vld));
         if (tbl[i].e_vld) begin
            chk($sformatf("vec%0d_pc", i), o_pc, tbl[i].e_pc);
            chk($sformatf("vec%0d_instr", i), o_instr, memw(tbl[i].e_pc));
         end
      end

      // Decoder stalled: only FIFO_DEPTH words may be granted, then released in order.
      n = 0;
      for (int i = 0; i < 10; i++) begin
         step(T, T, F, 32'h0, F);
         if (o_req && bus.imem_gnt) n++;
      end
      chk("stall_grants", 32'(n), 32'(DEPTH));
      step(T, T, F, 32'h0, T);
      chk("stall_release_pc0", o_pc, 32'h80);
      step(T, T, F, 32'h0, T);
      chk("stall_release_pc1", o_pc, 32'h84);

`ifdef IFU_MISALIGN_CHECK_EN
      do_reset();
      step(T, F, F, 32'h0, T);
      step(T, F, T, 32'h102, T);
      step(T, T, F, 32'h0, T);
      step(T, F, F, 32'h0, F);
      step(T, F, F, 32'h0, F);
      chk("mis_fault", 32'(o_fault), 32'h1);
      chk("mis_pc", o_pc, 32'h102);
      chk("mis_instr", o_instr, 32'h0);
      chk("mis_no_req", 32'(o_req), 32'h0);
      step(T, F, F, 32'h0, T);
      for (int i = 0; i < 4; i++) step(T, F, F, 32'h0, T);
      chk("mis_halted_vld", 32'(o_vld), 32'h0);
      step(T, F, T, 32'h200, T);
      step(T, F, F, 32'h0, T);
      chk("mis_resume_addr", o_addr, 32'h200);
      chk("mis_resume_req", 32'(o_req), 32'h1);
`endif

      do_reset();
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(3))
            0:       rpc = $urandom & 32'h0000_0FFC;
            1:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(3) * 4);
            2:       rpc = $urandom;
            default: rpc = 32'h100;
         endcase
         step($urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(19) == 0, rpc,
              $urandom_range(3) != 0);
      end

      // Mid-burst reset, then fetching restarts at the reset PC.
      do_reset();
      step(T, F, F, 32'h0, T);
      chk("post_rst_addr", o_addr, 32'h0);
      step(T, T, F, 32'h0, T);
      step(T, T, F, 32'h0, T);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
